mem_stage: RTL and testbench

- MEM stage of the five-stage CPU, sitting between EX and WB.
- Takes EX-stage results, performs word loads and stores against an internal data RAM with configurable multi-cycle access latency, and registers the results (MEM/WB pipeline register) for the WB stage.
- WB selects between the registered ALU result and the registered memory data using the registered m2reg.
- Raises a stall to freeze upstream stages while an access is in progress.

---
 rtl/mem_stage.sv | 133 +++++++++++++
 tb/tb_mem_stage.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MEM pipeline stage: word loads/stores against an internal RAM with multi-cycle latency, feeding the MEM/WB register.
// Optional build macro MEM_ALIGN_CHECK_EN adds the mem_err output and suppresses misaligned accesses.
module mem_stage #(
   parameter int ADDR_W  = 8,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ex_valid,
   input  logic        ex_wreg,
   input  logic        ex_m2reg,
   input  logic        ex_wmem,
   input  logic [4:0]  ex_rn,
   input  logic [31:0] ex_r_alu,
   input  logic [31:0] ex_b,
   output logic        stall,
   output logic        wb_valid,
   output logic        wb_wreg,
   output logic        wb_m2reg,
   output logic [4:0]  wb_rn,
   output logic [31:0] wb_r_alu,
   output logic [31:0] wb_m_o
`ifdef MEM_ALIGN_CHECK_EN
   ,
   output logic        mem_err
`endif
);

   localparam int         DEPTH  = 2 ** ADDR_W;
   localparam bit         LAT0   = (LATENCY == 0);
   localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t      state_reg;
   logic [3:0]  cnt_reg;

   logic [31:0] ram [DEPTH];
   logic [31:0] ram_q_reg;
   logic        load_sel_reg;
   logic        err_reg;

   logic [ADDR_W-1:0] word_idx;
   logic              mem_req;
   logic              misalign;
   logic              access_done;
   logic              stall_int;
   logic              ram_we;
   logic              load_done;

   assign word_idx = ex_r_alu[ADDR_W+1:2];
   assign mem_req  = ex_valid & (ex_m2reg | ex_wmem);

`ifdef MEM_ALIGN_CHECK_EN
   assign misalign = mem_req & (|ex_r_alu[1:0]);
   assign mem_err  = err_reg;
`else
   assign misalign = 1'b0;
`endif

   // With LATENCY=0 the access completes in the request cycle; otherwise on the last BUSY cycle.
   assign access_done = LAT0 ? mem_req
                             : (mem_req && state_reg == BUSY && cnt_reg == 4'd0);
   assign stall_int   = !LAT0 && ((state_reg == IDLE && mem_req) ||
                                  (state_reg == BUSY && cnt_reg != 4'd0));
   assign stall       = rst_n & stall_int;
   assign ram_we      = rst_n & access_done & ex_wmem & ~misalign;
   assign load_done   = access_done & ex_m2reg & ~ex_wmem & ~misalign;

   // RAM array kept free of reset so it maps onto block RAM; read port is read-first.
   always_ff @(posedge clk) begin
      if (ram_we) begin
         ram[word_idx] <= ex_b;
      end
      ram_q_reg <= ram[word_idx];
   end

   assign wb_m_o = load_sel_reg ? ram_q_reg : 32'd0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         cnt_reg   <= 4'd0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (!LAT0 && mem_req) begin
                  state_reg <= BUSY;
                  cnt_reg   <= LAT_M1;
               end
            end
            BUSY: begin
               if (cnt_reg != 4'd0) begin
                  cnt_reg <= cnt_reg - 4'd1;
               end else begin
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   // MEM/WB register: stall cycles load a bubble so WB sees each instruction once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_valid     <= 1'b0;
         wb_wreg      <= 1'b0;
         wb_m2reg     <= 1'b0;
         wb_rn        <= 5'd0;
         wb_r_alu     <= 32'd0;
         load_sel_reg <= 1'b0;
         err_reg      <= 1'b0;
      end else if (stall_int) begin
         wb_valid     <= 1'b0;
         wb_wreg      <= 1'b0;
         wb_m2reg     <= 1'b0;
         wb_rn        <= ex_rn;
         wb_r_alu     <= ex_r_alu;
         load_sel_reg <= 1'b0;
         err_reg      <= 1'b0;
      end else begin
         wb_valid     <= ex_valid;
         wb_wreg      <= ex_valid & ex_wreg & ~misalign;
         wb_m2reg     <= ex_valid & ex_m2reg;
         wb_rn        <= ex_rn;
         wb_r_alu     <= ex_r_alu;
         load_sel_reg <= load_done;
         err_reg      <= misalign;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected write-back tuples are queued at issue and compared on completion.
// Exercises the MEM_ALIGN_CHECK_EN feature when the macro is defined.
module tb_mem_stage;

   localparam int ADDR_W  = 8;
   localparam int LATENCY = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid, ex_wreg, ex_m2reg, ex_wmem;
   logic [4:0]  ex_rn;
   logic [31:0] ex_r_alu, ex_b;
   logic        stall, wb_valid, wb_wreg, wb_m2reg;
   logic [4:0]  wb_rn;
   logic [31:0] wb_r_alu, wb_m_o;
`ifdef MEM_ALIGN_CHECK_EN
   logic        mem_err;
`endif

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        v;
      logic        w;
      logic        m2;
      logic [4:0]  rn;
      logic [31:0] alu;
      logic [31:0] mo;
      logic        err;
   } exp_t;

   exp_t        sbq[$];
   logic [31:0] model_ram [2**ADDR_W];
   bit          written   [2**ADDR_W];

   mem_stage #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
      .clk(clk), .rst_n(rst_n),
      .ex_valid(ex_valid), .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_wmem(ex_wmem),
      .ex_rn(ex_rn), .ex_r_alu(ex_r_alu), .ex_b(ex_b),
      .stall(stall), .wb_valid(wb_valid), .wb_wreg(wb_wreg), .wb_m2reg(wb_m2reg),
      .wb_rn(wb_rn), .wb_r_alu(wb_r_alu), .wb_m_o(wb_m_o)
`ifdef MEM_ALIGN_CHECK_EN
      , .mem_err(mem_err)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Drive one instruction (called just after a rising edge), follow its stall window and check its write-back.
   task automatic issue(input logic v, input logic w, input logic m2, input logic wm,
                        input logic [4:0] rn, input logic [31:0] addr, input logic [31:0] b);
      exp_t            e;
      exp_t            got;
      logic            req;
      logic            mis;
      logic [ADDR_W-1:0] idx;
      int              n;
      req = v & (m2 | wm);
`ifdef MEM_ALIGN_CHECK_EN
      mis = req & (addr[1:0] != 2'b00);
`else
      mis = 1'b0;
`endif
      idx   = addr[ADDR_W+1:2];
      e.v   = v;
      e.w   = v & w & ~mis;
      e.m2  = v & m2;
      e.rn  = rn;
      e.alu = addr;
      e.mo  = (req && m2 && !wm && !mis) ? model_ram[idx] : 32'd0;
      e.err = mis;
      if (req && wm && !mis) begin
         model_ram[idx] = b;
         written[idx]   = 1'b1;
      end
      sbq.push_back(e);

      ex_valid = v; ex_wreg = w; ex_m2reg = m2; ex_wmem = wm;
      ex_rn = rn; ex_r_alu = addr; ex_b = b;
      #1;
      n = 0;
      while (stall === 1'b1 && n < 40) begin
         @(posedge clk); #1;
         chk("stall_bubble_valid", 32'(wb_valid), 32'd0);
         n++;
      end
      chk("stall_cycles", 32'(n), req ? 32'(LATENCY) : 32'd0);
      @(posedge clk); #1;
      got = sbq.pop_front();
      chk("wb_valid", 32'(wb_valid), 32'(got.v));
      chk("wb_wreg",  32'(wb_wreg),  32'(got.w));
      chk("wb_m2reg", 32'(wb_m2reg), 32'(got.m2));
      chk("wb_rn",    32'(wb_rn),    32'(got.rn));
      chk("wb_r_alu", wb_r_alu,      got.alu);
      chk("wb_m_o",   wb_m_o,        got.mo);
`ifdef MEM_ALIGN_CHECK_EN
      chk("mem_err",  32'(mem_err),  32'(got.err));
`endif
      $display("txn v=%0b w=%0b m2=%0b wm=%0b rn=%0d addr=%h b=%h stall=%0d m_o=%h",
               v, w, m2, wm, rn, addr, b, n, wb_m_o);
   endtask

   task automatic check_wb_zero(input string tag);
      chk({tag, "_stall"},  32'(stall),    32'd0);
      chk({tag, "_valid"},  32'(wb_valid), 32'd0);
      chk({tag, "_wreg"},   32'(wb_wreg),  32'd0);
      chk({tag, "_m2reg"},  32'(wb_m2reg), 32'd0);
      chk({tag, "_rn"},     32'(wb_rn),    32'd0);
      chk({tag, "_r_alu"},  wb_r_alu,      32'd0);
      chk({tag, "_m_o"},    wb_m_o,        32'd0);
   endtask

   initial begin
      logic [31:0] ra;
      logic        is_ld;
      rst_n = 1'b0;
      ex_valid = 1'b0; ex_wreg = 1'b0; ex_m2reg = 1'b0; ex_wmem = 1'b0;
      ex_rn = 5'd0; ex_r_alu = 32'd0; ex_b = 32'd0;

      // Reset with random inputs applied.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         ex_valid = 1'($urandom); ex_wreg = 1'($urandom); ex_m2reg = 1'($urandom);
         ex_wmem  = 1'($urandom); ex_rn = 5'($urandom); ex_r_alu = $urandom; ex_b = $urandom;
         #1;
         check_wb_zero("reset");
      end
      @(negedge clk);
      ex_valid = 1'b0; ex_wreg = 1'b0; ex_m2reg = 1'b0; ex_wmem = 1'b0;
      ex_rn = 5'd0; ex_r_alu = 32'd0; ex_b = 32'd0;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check_wb_zero("post_reset");
      @(posedge clk); #1;

      issue(1, 1, 0, 0, 5'd5, 32'h0000_1234, 32'd0);
      issue(1, 0, 0, 1, 5'd0, 32'h0000_0040, 32'hDEAD_BEEF);
      issue(1, 1, 1, 0, 5'd7, 32'h0000_0040, 32'd0);
      issue(1, 0, 0, 1, 5'd0, 32'h0000_0400, 32'h0000_0011);
      issue(1, 1, 1, 0, 5'd8, 32'h0000_0000, 32'd0);
      issue(1, 0, 0, 1, 5'd0, 32'h0000_0080, 32'h0000_5555);
      issue(0, 1, 1, 1, 5'd9, 32'h0000_0044, 32'h1111_2222);
      issue(1, 1, 1, 1, 5'd3, 32'h0000_0044, 32'h0000_CAFE);
      issue(1, 1, 1, 0, 5'd4, 32'h0000_0044, 32'd0);

      // Reset in the second stall cycle of a store: the store must be dropped.
      ex_valid = 1'b1; ex_wreg = 1'b0; ex_m2reg = 1'b0; ex_wmem = 1'b1;
      ex_rn = 5'd0; ex_r_alu = 32'h0000_0080; ex_b = 32'h0000_AAAA;
      #1;
      chk("abort_stall_t0", 32'(stall), 32'd1);
      @(posedge clk); #1;
      chk("abort_stall_t1", 32'(stall), 32'd1);
      rst_n = 1'b0;
      #1;
      check_wb_zero("abort_reset");
      ex_valid = 1'b0; ex_wmem = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("abort_idle_stall", 32'(stall), 32'd0);
      issue(1, 1, 1, 0, 5'd10, 32'h0000_0080, 32'd0);

`ifdef MEM_ALIGN_CHECK_EN
      issue(1, 1, 0, 1, 5'd11, 32'h0000_0041, 32'h7777_7777);
      issue(1, 1, 1, 0, 5'd12, 32'h0000_0040, 32'd0);
      issue(1, 1, 1, 0, 5'd13, 32'h0000_0042, 32'd0);
`endif

      // Random back-to-back mix over a small address window.
      for (int i = 0; i < 12; i++) begin
         ra    = {22'd0, 3'($urandom_range(0, 7)), 5'd0, 2'($urandom)};
         is_ld = 1'($urandom);
         if (is_ld && !written[ra[ADDR_W+1:2]]) is_ld = 1'b0;
         if (i % 4 == 3)
            issue(1, 1, 0, 0, 5'($urandom), $urandom, $urandom);
         else if (is_ld)
            issue(1, 1, 1, 0, 5'($urandom), ra, 32'd0);
         else
            issue(1, 0, 0, 1, 5'($urandom), ra, $urandom);
      end

      chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
